line_memory_responder: RTL and testbench

Main-memory responder for the cache line interface. It serves 128-bit line reads from the instruction cache and data cache, and 128-bit line write-backs from the data cache. Requests are served one at a time against an internal line array, with a fixed, configurable access latency. It sits below both caches, where a bench or top level needs a self-contained memory endpoint in place of the full controller.

---
 rtl/line_memory_responder_if.sv | 29 ++
 rtl/line_memory_responder.sv | 139 +++++++++++++
 tb/tb_line_memory_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_memory_responder_if.sv
// Cache line bus between the I/D caches (master) and the line memory responder (slave).
// Requests are level signals; completions are one-cycle pulses.
interface line_memory_responder_if;
   logic          reqI_cache;
   logic [25:0]   reqAddrI_mem;
   logic          reqD_cache;
   logic [25:0]   reqAddrD_mem;
   logic          reqD_cache_write;
   logic [25:0]   reqAddrD_write_mem;
   logic [127:0]  data_from_cache;
   logic [127:0]  data_to_cache;
   logic          read_ready_for_icache;
   logic          read_ready_for_dcache;
   logic          written_data_ack;

   modport master (
      output reqI_cache, reqAddrI_mem,
      output reqD_cache, reqAddrD_mem,
      output reqD_cache_write, reqAddrD_write_mem, data_from_cache,
      input  data_to_cache, read_ready_for_icache, read_ready_for_dcache, written_data_ack
   );

   modport slave (
      input  reqI_cache, reqAddrI_mem,
      input  reqD_cache, reqAddrD_mem,
      input  reqD_cache_write, reqAddrD_write_mem, data_from_cache,
      output data_to_cache, read_ready_for_icache, read_ready_for_dcache, written_data_ack
   );
endinterface

// File: rtl/line_memory_responder.sv
// Fixed-latency line memory serving I/D line reads and D write-backs one at a time.
// Optional MEMRSP_PROTO_CHECK_EN adds a sticky proto_err output and aborts on dropped requests.
module line_memory_responder #(
   parameter int LATENCY     = 10,
   parameter int DEPTH_LINES = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   line_memory_responder_if.slave bus
`ifdef MEMRSP_PROTO_CHECK_EN
   ,
   output logic                   proto_err
`endif
);

   localparam int         IDX_W    = $clog2(DEPTH_LINES);
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   localparam logic [1:0] KIND_I = 2'd0;
   localparam logic [1:0] KIND_D = 2'd1;
   localparam logic [1:0] KIND_W = 2'd2;

   logic [127:0]     mem_array [DEPTH_LINES];

   logic [1:0]       state_reg;
   logic [1:0]       kind_reg;
   logic [7:0]       cnt_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [127:0]     wdata_reg;
   logic [127:0]     rdata_reg;
   logic             pulse_i_reg;
   logic             pulse_d_reg;
   logic             ack_reg;

`ifdef MEMRSP_PROTO_CHECK_EN
   logic             proto_err_reg;
   logic             level_held;

   always_comb begin
      level_held = 1'b0;
      case (kind_reg)
         KIND_W:  level_held = bus.reqD_cache_write;
         KIND_D:  level_held = bus.reqD_cache;
         default: level_held = bus.reqI_cache;
      endcase
   end

   assign proto_err = proto_err_reg;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         kind_reg    <= KIND_I;
         cnt_reg     <= 8'd0;
         idx_reg     <= '0;
         wdata_reg   <= '0;
         rdata_reg   <= '0;
         pulse_i_reg <= 1'b0;
         pulse_d_reg <= 1'b0;
         ack_reg     <= 1'b0;
`ifdef MEMRSP_PROTO_CHECK_EN
         proto_err_reg <= 1'b0;
`endif
      end else begin
         pulse_i_reg <= 1'b0;
         pulse_d_reg <= 1'b0;
         ack_reg     <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Fixed priority: write-back, then D read, then I read
               if (bus.reqD_cache_write) begin
                  kind_reg  <= KIND_W;
                  idx_reg   <= bus.reqAddrD_write_mem[IDX_W-1:0];
                  wdata_reg <= bus.data_from_cache;
                  cnt_reg   <= CNT_LOAD;
                  state_reg <= BUSY;
               end else if (bus.reqD_cache) begin
                  kind_reg  <= KIND_D;
                  idx_reg   <= bus.reqAddrD_mem[IDX_W-1:0];
                  cnt_reg   <= CNT_LOAD;
                  state_reg <= BUSY;
               end else if (bus.reqI_cache) begin
                  kind_reg  <= KIND_I;
                  idx_reg   <= bus.reqAddrI_mem[IDX_W-1:0];
                  cnt_reg   <= CNT_LOAD;
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
`ifdef MEMRSP_PROTO_CHECK_EN
               if (!level_held) begin
                  proto_err_reg <= 1'b1;
                  state_reg     <= GAP;
               end else
`endif
               if (cnt_reg == 8'd0) begin
                  // Read data and pulses are registered here so they appear together in RESP
                  state_reg <= RESP;
                  case (kind_reg)
                     KIND_W: ack_reg <= 1'b1;
                     KIND_D: begin
                        rdata_reg   <= mem_array[idx_reg];
                        pulse_d_reg <= 1'b1;
                     end
                     default: begin
                        rdata_reg   <= mem_array[idx_reg];
                        pulse_i_reg <= 1'b1;
                     end
                  endcase
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            RESP:    state_reg <= GAP;
            GAP:     state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Array is not reset; a reset mid-transaction leaves state_reg out of RESP, so no write lands
   always_ff @(posedge clk) begin
      if (state_reg == RESP && kind_reg == KIND_W) begin
         mem_array[idx_reg] <= wdata_reg;
      end
   end

   assign bus.data_to_cache         = rdata_reg;
   assign bus.read_ready_for_icache = pulse_i_reg;
   assign bus.read_ready_for_dcache = pulse_d_reg;
   assign bus.written_data_ack      = ack_reg;

endmodule

// File: tb/tb_line_memory_responder.sv
// Scoreboard bench for line_memory_responder: expected responses are queued at issue time
// and compared when a pulse appears. Build with MEMRSP_PROTO_CHECK_EN to cover the checker.
module tb_line_memory_responder;

   localparam int LATENCY = 10;
   localparam int DEPTH   = 1024;
   localparam int K_I = 0;
   localparam int K_D = 1;
   localparam int K_W = 2;

   typedef struct {
      int           kind;
      int           cyc;
      logic [127:0] data;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;
   exp_t sb_q [$];
   logic [127:0] model [int];
   logic [127:0] last_read;
`ifdef MEMRSP_PROTO_CHECK_EN
   logic proto_err;
`endif

   line_memory_responder_if bus ();

   line_memory_responder #(
      .LATENCY     (LATENCY),
      .DEPTH_LINES (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MEMRSP_PROTO_CHECK_EN
      ,
      .proto_err (proto_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: every pulse pops one expectation
   always @(negedge clk) begin
      if (reset && (bus.read_ready_for_icache || bus.read_ready_for_dcache || bus.written_data_ack)) begin
         int   kind;
         exp_t e;
         kind = bus.written_data_ack ? K_W : (bus.read_ready_for_dcache ? K_D : K_I);
         check_value("onehot", 128'(int'(bus.read_ready_for_icache) + int'(bus.read_ready_for_dcache)
                     + int'(bus.written_data_ack)), 128'd1);
         if (sb_q.size() == 0) begin
            check_value("unexpected_pulse", 128'(kind), 128'hFFFF);
         end else begin
            e = sb_q.pop_front();
            check_value("kind", 128'(kind), 128'(e.kind));
            check_value("cycle", 128'(cyc), 128'(e.cyc));
            if (e.kind == K_W) begin
               check_value("data_hold_on_write", bus.data_to_cache, last_read);
            end else begin
               check_value("read_data", bus.data_to_cache, e.data);
               last_read = e.data;
            end
            $display("txn kind=%0d cycle=%0d data=%h", kind, cyc, bus.data_to_cache);
         end
      end
   end

   function automatic int idx_of(input logic [25:0] addr);
      return int'(addr) % DEPTH;
   endfunction

   // Queue the expectation for a request accepted at the end of the current cycle (+delay)
   task automatic push_exp(input int kind, input logic [25:0] addr, input logic [127:0] wdata, input int delay);
      exp_t e;
      e.kind = kind;
      e.cyc  = cyc + delay;
      if (kind == K_W) begin
         model[idx_of(addr)] = wdata;
         e.data = wdata;
      end else begin
         e.data = model[idx_of(addr)];
      end
      sb_q.push_back(e);
   endtask

   task automatic set_req(input int kind, input logic val, input logic [25:0] addr, input logic [127:0] wdata);
      case (kind)
         K_W: begin
            bus.reqD_cache_write   = val;
            bus.reqAddrD_write_mem = addr;
            bus.data_from_cache    = wdata;
         end
         K_D: begin
            bus.reqD_cache   = val;
            bus.reqAddrD_mem = addr;
         end
         default: begin
            bus.reqI_cache   = val;
            bus.reqAddrI_mem = addr;
         end
      endcase
   endtask

   task automatic drop_req(input int kind);
      case (kind)
         K_W:     bus.reqD_cache_write = 1'b0;
         K_D:     bus.reqD_cache = 1'b0;
         default: bus.reqI_cache = 1'b0;
      endcase
   endtask

   // Wait for the pulse of 'kind', then drop its level in the following (GAP) cycle
   task automatic wait_and_drop(input int kind);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 * LATENCY + 10 && !seen; i++) begin
         @(negedge clk);
         case (kind)
            K_W:     seen = bus.written_data_ack;
            K_D:     seen = bus.read_ready_for_dcache;
            default: seen = bus.read_ready_for_icache;
         endcase
      end
      if (!seen) check_value("timeout", 128'(kind), 128'hFFFF);
      @(posedge clk);
      #1;
      drop_req(kind);
   endtask

   task automatic run_single(input int kind, input logic [25:0] addr, input logic [127:0] wdata);
      @(posedge clk);
      #1;
      set_req(kind, 1'b1, addr, wdata);
      push_exp(kind, addr, wdata, LATENCY);
      wait_and_drop(kind);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_value({tag, "_data"}, bus.data_to_cache, 128'd0);
      check_value({tag, "_pulses"}, {125'd0, bus.read_ready_for_icache, bus.read_ready_for_dcache,
                  bus.written_data_ack}, 128'd0);
`ifdef MEMRSP_PROTO_CHECK_EN
      check_value({tag, "_proto_err"}, 128'(proto_err), 128'd0);
`endif
   endtask

   localparam logic [127:0] D_DEAD = 128'hDEADBEEF_00000000_00000000_00000001;
   localparam logic [127:0] D_A    = 128'h11112222_33334444_55556666_77778888;
   localparam logic [127:0] D_B    = 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF;
   localparam logic [127:0] D_X    = 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0;
   localparam logic [127:0] D_W2   = 128'hFEEDFACE_00000010_00000020_00000030;

   initial begin
      checks    = 0;
      failures  = 0;
      last_read = '0;
      reset     = 1'b0;
      bus.reqI_cache = 1'b0; bus.reqAddrI_mem = '0;
      bus.reqD_cache = 1'b0; bus.reqAddrD_mem = '0;
      bus.reqD_cache_write = 1'b0; bus.reqAddrD_write_mem = '0; bus.data_from_cache = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset = 1'b1;

      // Write-back then read-back of the same line
      run_single(K_W, 26'h0000005, D_DEAD);
      run_single(K_D, 26'h0000005, 128'd0);

      // Write and D read raised together: write first, read accepted 12 cycles later
      @(posedge clk);
      #1;
      set_req(K_W, 1'b1, 26'h0000010, D_W2);
      set_req(K_D, 1'b1, 26'h0000010, 128'd0);
      push_exp(K_W, 26'h0000010, D_W2, LATENCY);
      push_exp(K_D, 26'h0000010, 128'd0, 2 * LATENCY + 2);
      wait_and_drop(K_W);
      wait_and_drop(K_D);

      // I and D raised together: D first
      @(posedge clk);
      #1;
      set_req(K_I, 1'b1, 26'h0000010, 128'd0);
      set_req(K_D, 1'b1, 26'h0000005, 128'd0);
      push_exp(K_D, 26'h0000005, 128'd0, LATENCY);
      push_exp(K_I, 26'h0000010, 128'd0, 2 * LATENCY + 2);
      wait_and_drop(K_D);
      wait_and_drop(K_I);

      // Aliasing: upper address bits ignored
      run_single(K_W, 26'h0000403, D_X);
      run_single(K_I, 26'h0000003, 128'd0);

      // Reset during a write-back aborts it
      run_single(K_W, 26'h0000007, D_A);
      run_single(K_D, 26'h0000007, 128'd0);
      @(posedge clk);
      #1;
      set_req(K_W, 1'b1, 26'h0000007, D_B);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_outputs_zero("reset_abort");
      last_read = '0;
      repeat (2) @(posedge clk);
      #1;
      drop_req(K_W);
      reset = 1'b1;
      repeat (LATENCY + 4) @(negedge clk);
      run_single(K_D, 26'h0000007, 128'd0);

      // Requester drops its level mid-transaction
      @(posedge clk);
      #1;
      set_req(K_D, 1'b1, 26'h0000005, 128'd0);
`ifndef MEMRSP_PROTO_CHECK_EN
      push_exp(K_D, 26'h0000005, 128'd0, LATENCY);
`endif
      repeat (3) @(posedge clk);
      #1;
      drop_req(K_D);
`ifdef MEMRSP_PROTO_CHECK_EN
      @(negedge clk);
      @(negedge clk);
      check_value("proto_err_set", 128'(proto_err), 128'd1);
      repeat (LATENCY + 4) @(negedge clk);
      check_value("proto_err_sticky", 128'(proto_err), 128'd1);
`else
      repeat (LATENCY + 4) @(negedge clk);
`endif

      repeat (4) @(negedge clk);
      check_value("scoreboard_empty", 128'(sb_q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
